// File: rtl/microcode_sequencer_if.sv
// microcode_sequencer_if
//   Control-unit bus between the microcode sequencer and its surroundings.
//   master : drives step_en/opcode/flags, observes the control word and state
//   slave  : the sequencer itself
//   step_en     advance enable (low stalls)
//   opcode      IR opcode, valid from T2
//   carry_flag  ALU CF
//   zero_flag   ALU ZF
//   control_out 15-bit datapath control word
//   step        current micro-step 0..5
//   halted      sticky HLT indication
interface microcode_sequencer_if;
   logic        step_en;
   logic [3:0]  opcode;
   logic        carry_flag;
   logic        zero_flag;
   logic [14:0] control_out;
   logic [2:0]  step;
   logic        halted;

   modport master (output step_en, opcode, carry_flag, zero_flag,
                   input  control_out, step, halted);
   modport slave  (input  step_en, opcode, carry_flag, zero_flag,
                   output control_out, step, halted);
endinterface

// File: rtl/microcode_sequencer.sv
// microcode_sequencer
//   Control unit for the 8-bit SAP-style CPU. Holds the micro-step counter
//   and decodes {opcode, step, flags} into the datapath control word.
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    slave side of microcode_sequencer_if (step_en, opcode, flags in;
//          control_out, step, halted out)
//   Control word: [14]Cp [13]Ep [12]Lp [11]nLma [10]nLmd [9]nCE [8]nLr
//                 [7]nLi [6]nEi [5]nLa [4]Ea [3]sub [2]Eu [1]nLb [0]nLo
module microcode_sequencer #(
   parameter bit          EARLY_END = 1'b1,
   parameter logic [14:0] IDLE_WORD = 15'h0FE3
) (
   input logic                   clk,
   input logic                   rst_n,
   microcode_sequencer_if.slave  bus
);
   typedef enum logic [2:0] {T0, T1, T2, T3, T4, T5} step_t;

   localparam int CP = 14, EP = 13, LP = 12, NLMA = 11, NLMD = 10, NCE = 9,
                  NLR = 8, NLI = 7, NEI = 6, NLA = 5, EA = 4, SUB = 3,
                  EU = 2, NLB = 1, NLO = 0;

   localparam logic [3:0] OP_LDA = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3,
                          OP_STA = 4'h4, OP_LDI = 4'h5, OP_JMP = 4'h6,
                          OP_JC  = 4'h7, OP_JZ  = 4'h8, OP_OUT = 4'hE,
                          OP_HLT = 4'hF;

   step_t       r_step;
   logic        r_halted;
   step_t       w_last;
   logic [14:0] w_word;

   // Last step that does useful work for the current opcode.
   always_comb begin
      w_last = T1;
      case (bus.opcode)
         OP_LDA:                                 w_last = T3;
         OP_ADD, OP_SUB, OP_STA:                 w_last = T4;
         OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT,
         OP_HLT:                                 w_last = T2;
         default:                                w_last = T1;
      endcase
   end

   // Control word decode. Flags only matter in T2, since jumps are only
   // decoded there.
   always_comb begin
      w_word = IDLE_WORD;
      if (rst_n && !r_halted && bus.step_en) begin
         case (r_step)
            T0: begin
               w_word[EP] = 1'b1; w_word[NLMA] = 1'b0;
            end
            T1: begin
               w_word[CP] = 1'b1; w_word[NCE] = 1'b0; w_word[NLI] = 1'b0;
            end
            T2: begin
               case (bus.opcode)
                  OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                     w_word[NEI] = 1'b0; w_word[NLMA] = 1'b0;
                  end
                  OP_LDI: begin
                     w_word[NEI] = 1'b0; w_word[NLA] = 1'b0;
                  end
                  OP_JMP, OP_JC, OP_JZ: begin
                     if (bus.opcode == OP_JMP ||
                         (bus.opcode == OP_JC && bus.carry_flag) ||
                         (bus.opcode == OP_JZ && bus.zero_flag)) begin
                        w_word[NEI] = 1'b0; w_word[LP] = 1'b1;
                     end
                  end
                  OP_OUT: begin
                     w_word[EA] = 1'b1; w_word[NLO] = 1'b0;
                  end
                  default: ;
               endcase
            end
            T3: begin
               case (bus.opcode)
                  OP_LDA: begin
                     w_word[NCE] = 1'b0; w_word[NLA] = 1'b0;
                  end
                  OP_ADD, OP_SUB: begin
                     w_word[NCE] = 1'b0; w_word[NLB] = 1'b0;
                  end
                  OP_STA: begin
                     w_word[EA] = 1'b1; w_word[NLMD] = 1'b0;
                  end
                  default: ;
               endcase
            end
            T4: begin
               case (bus.opcode)
                  OP_ADD, OP_SUB: begin
                     w_word[EU]  = 1'b1; w_word[NLA] = 1'b0;
                     w_word[SUB] = (bus.opcode == OP_SUB);
                  end
                  OP_STA: w_word[NLR] = 1'b0;
                  default: ;
               endcase
            end
            default: ;
         endcase
      end
   end

   // Step counter and sticky halt. HLT freezes step at T2 rather than
   // wrapping, so the halted state remains visible on step.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_step   <= T0;
         r_halted <= 1'b0;
      end else if (bus.step_en && !r_halted) begin
         if (r_step == T2 && bus.opcode == OP_HLT)
            r_halted <= 1'b1;
         else if ((EARLY_END && r_step == w_last) || r_step == T5)
            r_step <= T0;
         else
            r_step <= step_t'(r_step + 3'd1);
      end
   end

   assign bus.control_out = w_word;
   assign bus.step        = r_step;
   assign bus.halted      = r_halted;
endmodule
